hrange: RTL and testbench

- Hardware generator equivalent to the Python generator `i = base; while i < limit: yield i; i += step`.
- A single `_start` pulse launches the sequence. The block then emits one signed value per cycle on `_0`, qualified by `_valid`.
- `_wait` stalls the sequence. `_ready` signals idle/done.
- Sits as a leaf "function-call" block under a host FSM that drives arguments and consumes yielded values.

---
 rtl/hrange.sv | 101 ++++++++++
 tb/tb_hrange.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/hrange.sv
// Hardware range generator: emits base, base+step, ... while the value stays below limit.
// One value per unstalled cycle, launched by a start pulse while idle.
module hrange #(
  parameter int WIDTH = 32
) (
  input  logic             _clock,
  input  logic             _reset,
  input  logic             _start,
  input  logic             _wait,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] step,
  output logic             _ready,
  output logic             _valid,
  output logic [WIDTH-1:0] _0
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             valid_q, valid_d;

  // One extra bit so an overflowing increment compares as large and terminates instead of wrapping.
  logic [WIDTH:0]   next_sum;
  logic [WIDTH:0]   limit_ext;

  assign next_sum  = {value_q[WIDTH-1], value_q} + {step_q[WIDTH-1], step_q};
  assign limit_ext = {limit_q[WIDTH-1], limit_q};

  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      state_q <= IDLE;
      limit_q <= '0;
      step_q  <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      step_q  <= step_d;
      value_q <= value_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    step_d  = step_q;
    value_d = value_q;
    valid_d = valid_q;

    case (state_q)
      IDLE: begin
        if (_start) begin
          limit_d = limit;
          step_d  = step;
          state_d = RUN;
          if ($signed(base) < $signed(limit)) begin
            value_d = base;
            valid_d = 1'b1;
          end else begin
            valid_d = 1'b0;
          end
        end
      end

      RUN: begin
        // An empty range spends one RUN cycle with valid low, then falls back to IDLE.
        if (!_wait) begin
          if (valid_q) begin
            if ($signed(next_sum) < $signed(limit_ext)) begin
              value_d = next_sum[WIDTH-1:0];
            end else begin
              valid_d = 1'b0;
              state_d = IDLE;
            end
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  assign _ready = (state_q == IDLE);
  assign _valid = valid_q;
  assign _0     = value_q;

endmodule

// File: tb/tb_hrange.sv
// Bench for hrange: directed scenarios plus randomized ranges, checked against
// a Python-style generator model that builds the expected value list up front.
module tb_hrange;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        stall;
  logic [31:0] base_val;
  logic [31:0] limit_val;
  logic [31:0] step_val;
  logic        ready;
  logic        valid;
  logic [31:0] out_val;

  int          num_checks;
  int          num_fail;
  longint      exp_q[$];
  logic [31:0] last_out;

  hrange #(.WIDTH(32)) dut (
    ._clock(clock),
    ._reset(reset_n),
    ._start(start),
    ._wait (stall),
    .base  (base_val),
    .limit (limit_val),
    .step  (step_val),
    ._ready(ready),
    ._valid(valid),
    ._0    (out_val)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: i = base; while i < limit: yield i; i += step (capped for endless ranges).
  function automatic bit build_expected(input longint b, input longint l, input longint s,
                                        input int max_vals);
    longint i;
    exp_q.delete();
    i = b;
    while (i < l && exp_q.size() < max_vals) begin
      exp_q.push_back(i);
      i += s;
    end
    return (i >= l);
  endfunction

  task automatic checkOutput(input string tag, input logic exp_ready, input logic exp_valid,
                             input logic [31:0] exp_out);
    num_checks++;
    assert (ready === exp_ready) else begin
      num_fail++;
      $error("[TB] FAIL %s ready observed=%0b expected=%0b", tag, ready, exp_ready);
    end
    num_checks++;
    assert (valid === exp_valid) else begin
      num_fail++;
      $error("[TB] FAIL %s valid observed=%0b expected=%0b", tag, valid, exp_valid);
    end
    num_checks++;
    assert (out_val === exp_out) else begin
      num_fail++;
      $error("[TB] FAIL %s out observed=%0h expected=%0h", tag, out_val, exp_out);
    end
  endtask

  task automatic applyStimulus(input string tag, input longint b, input longint l, input longint s,
                               input int max_vals, input bit rand_stall,
                               input longint stall_val, input int stall_len);
    bit     finite;
    int     idx;
    int     stall_left;
    bit     stalled_once;
    longint v;

    finite = build_expected(b, l, s, max_vals);
    @(negedge clock);
    start     = 1'b1;
    base_val  = 32'(b);
    limit_val = 32'(l);
    step_val  = 32'(s);
    stall     = rand_stall ? 1'(($urandom_range(0, 1))) : 1'b0;
    @(negedge clock);
    start = 1'b0;

    if (exp_q.size() == 0) begin
      checkOutput({tag, "_empty_busy"}, 1'b0, 1'b0, last_out);
      stall = 1'b0;
      @(negedge clock);
      checkOutput({tag, "_empty_done"}, 1'b1, 1'b0, last_out);
      return;
    end

    idx          = 0;
    stall_left   = 0;
    stalled_once = 1'b0;
    while (idx < exp_q.size()) begin
      v = exp_q[idx];
      checkOutput({tag, "_value"}, 1'b0, 1'b1, 32'(v));
      last_out = 32'(v);
      if (!stalled_once && stall_len > 0 && v == stall_val) begin
        stall_left   = stall_len;
        stalled_once = 1'b1;
      end
      if (stall_left > 0) begin
        stall = 1'b1;
        stall_left--;
      end else begin
        stall = rand_stall && ($urandom_range(0, 3) == 0);
      end
      // A start pulse with fresh arguments while running must be ignored.
      start     = 1'(($urandom_range(0, 1)));
      base_val  = $urandom;
      limit_val = $urandom;
      step_val  = $urandom;
      @(negedge clock);
      if (!stall) idx++;
    end
    start = 1'b0;
    stall = 1'b0;

    if (finite) begin
      checkOutput({tag, "_done"}, 1'b1, 1'b0, last_out);
    end else begin
      #2 reset_n = 1'b0;
      #1 checkOutput({tag, "_abort"}, 1'b1, 1'b0, 32'h0);
      last_out = 32'h0;
      @(negedge clock);
      reset_n = 1'b1;
    end
  endtask

  initial begin
    longint b;
    longint l;
    longint s;

    num_checks = 0;
    num_fail   = 0;
    last_out   = 32'h0;
    reset_n    = 1'b0;
    start      = 1'b0;
    stall      = 1'b0;
    base_val   = 32'h0;
    limit_val  = 32'h0;
    step_val   = 32'h0;

    #12 checkOutput("reset", 1'b1, 1'b0, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checkOutput("idle", 1'b1, 1'b0, 32'h0);

    applyStimulus("even", 0, 10, 2, 1000, 1'b0, 0, 0);
    applyStimulus("empty", 5, 5, 1, 1000, 1'b0, 0, 0);
    applyStimulus("negbase", -3, 2, 2, 1000, 1'b0, 0, 0);
    applyStimulus("waited", 0, 10, 3, 1000, 1'b0, 3, 3);
    applyStimulus("overflow", 64'h7FFFFFF0, 64'h7FFFFFFF, 64'h10, 1000, 1'b0, 0, 0);
    applyStimulus("abort", 0, 100, 1, 5, 1'b0, 0, 0);
    applyStimulus("endless", 4, 9, 0, 6, 1'b1, 0, 0);
    applyStimulus("descend", 3, 7, -2, 8, 1'b0, 0, 0);

    for (int n = 0; n < 24; n++) begin
      b = longint'(int'($urandom_range(0, 100)) - 50);
      l = longint'(int'($urandom_range(0, 100)) - 50);
      if ($urandom_range(0, 9) == 0) s = -longint'($urandom_range(0, 3));
      else s = longint'($urandom_range(1, 7));
      applyStimulus("rand", b, l, s, 200, 1'b1, 0, 0);
    end

    for (int n = 0; n < 6; n++) begin
      b = 64'h7FFFFFFF - longint'($urandom_range(0, 40));
      l = 64'h7FFFFFFF - longint'($urandom_range(0, 10));
      s = longint'($urandom_range(1, 32'h3FFFFFFF));
      applyStimulus("randtop", b, l, s, 200, 1'b1, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
